// File: rtl/boot_stream_loader.sv
// boot_stream_loader: deserialises a framed boot image (length header,
// N payload words, checksum word) from an asynchronous strobe/data pin pair.
// Each payload word is presented with an auto-incrementing address and a
// one-cycle write strobe. Sticky done/error flags report the frame outcome.
module boot_stream_loader #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int LSB_FIRST      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dataOnPin,
  input  logic                  dataPin,
  output logic                  ready,
  output logic [WORD_WIDTH-1:0] out,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BCW = $clog2(WORD_WIDTH + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW  = ADDR_WIDTH + 1;
  // Wide enough to hold both a full header word and 2^ADDR_WIDTH.
  localparam int CW  = (WORD_WIDTH > IW) ? WORD_WIDTH : IW;

  localparam logic [BCW-1:0] LAST_BIT     = BCW'(WORD_WIDTH - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  MAX_LEN      = CW'(1) << ADDR_WIDTH;
  localparam logic [IW-1:0]  IDX_ONE      = IW'(1);

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t                state_r;
  logic                  on_s1_r, on_s2_r, on_s3_r;
  logic                  dat_s1_r, dat_s2_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic [BCW-1:0]        bit_cnt_r;
  logic [TCW-1:0]        idle_cnt_r;
  logic [WORD_WIDTH-1:0] sum_r;
  logic [IW-1:0]         index_r;
  logic [IW-1:0]         len_r;

  logic                  bit_event_s;
  logic                  word_done_s;
  logic [WORD_WIDTH-1:0] next_word_s;
  logic [CW-1:0]         len_ext_s;

  assign bit_event_s = on_s2_r & ~on_s3_r;
  assign word_done_s = bit_event_s & (bit_cnt_r == LAST_BIT);
  assign len_ext_s   = CW'(next_word_s);

  // Shift register contents after absorbing the current synchronised data bit.
  always_comb begin
    next_word_s = shift_r;
    if (LSB_FIRST != 0) begin
      next_word_s = {dat_s2_r, shift_r[WORD_WIDTH-1:1]};
    end else begin
      next_word_s = {shift_r[WORD_WIDTH-2:0], dat_s2_r};
    end
  end

  // Two-flop synchronisers on both pins plus an edge-detect flop on the strobe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      on_s1_r  <= 1'b0;
      on_s2_r  <= 1'b0;
      on_s3_r  <= 1'b0;
      dat_s1_r <= 1'b0;
      dat_s2_r <= 1'b0;
    end else begin
      on_s1_r  <= dataOnPin;
      on_s2_r  <= on_s1_r;
      on_s3_r  <= on_s2_r;
      dat_s1_r <= dataPin;
      dat_s2_r <= dat_s1_r;
    end
  end

  // Deserialiser with idle timeout that drops a stalled partial word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      idle_cnt_r <= '0;
    end else if (bit_event_s) begin
      shift_r    <= next_word_s;
      idle_cnt_r <= '0;
      if (word_done_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + BCW'(1);
      end
    end else if (bit_cnt_r != '0) begin
      if (idle_cnt_r == TIMEOUT_LAST) begin
        shift_r    <= '0;
        bit_cnt_r  <= '0;
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + TCW'(1);
      end
    end else begin
      idle_cnt_r <= '0;
    end
  end

  // Frame FSM: header, payload words, checksum; outputs registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_HDR;
      ready   <= 1'b0;
      out     <= '0;
      addr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      sum_r   <= '0;
      index_r <= '0;
      len_r   <= '0;
    end else begin
      ready <= 1'b0;
      if (word_done_s) begin
        case (state_r)
          ST_HDR: begin
            if (len_ext_s > MAX_LEN) begin
              error   <= 1'b1;
              state_r <= ST_ERR;
            end else if (len_ext_s == '0) begin
              sum_r   <= '0;
              busy    <= 1'b1;
              state_r <= ST_CHECK;
            end else begin
              len_r   <= len_ext_s[IW-1:0];
              index_r <= '0;
              sum_r   <= '0;
              busy    <= 1'b1;
              state_r <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            out     <= next_word_s;
            addr    <= index_r[ADDR_WIDTH-1:0];
            ready   <= 1'b1;
            sum_r   <= sum_r + next_word_s;
            index_r <= index_r + IDX_ONE;
            if ((index_r + IDX_ONE) == len_r) begin
              state_r <= ST_CHECK;
            end else begin
              state_r <= ST_LOAD;
            end
          end
          ST_CHECK: begin
            busy <= 1'b0;
            if (next_word_s == sum_r) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              error   <= 1'b1;
              state_r <= ST_ERR;
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          ST_ERR: begin
            state_r <= ST_ERR;
          end
          default: begin
            // Unreachable encoding: fail safe into the error state.
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b1;
            state_r <= ST_ERR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench for boot_stream_loader: three instances (defaults,
// LSB-first, 2-bit address) driven through serial frames.
module tb_boot_stream_loader;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic a_on = 1'b0, a_dat = 1'b0;
  logic b_on = 1'b0, b_dat = 1'b0;
  logic c_on = 1'b0, c_dat = 1'b0;

  logic        a_ready, a_busy, a_done, a_error;
  logic [31:0] a_out;
  logic [11:0] a_addr;
  logic        b_ready, b_busy, b_done, b_error;
  logic [31:0] b_out;
  logic [11:0] b_addr;
  logic        c_ready, c_busy, c_done, c_error;
  logic [31:0] c_out;
  logic [1:0]  c_addr;

  int checks = 0;
  int failures = 0;

  // Ready-pulse logs written only by the monitor.
  logic [31:0] a_out_log [0:63];
  logic [11:0] a_addr_log [0:63];
  logic [31:0] b_out_log [0:63];
  logic [11:0] b_addr_log [0:63];
  logic [31:0] c_out_log [0:63];
  logic [11:0] c_addr_log [0:63];
  int a_cnt = 0, b_cnt = 0, c_cnt = 0;
  int a_double = 0, b_double = 0, c_double = 0;
  int a_busy_cyc = 0;
  logic a_ready_q = 1'b0, b_ready_q = 1'b0, c_ready_q = 1'b0;

  always #5 clock = ~clock;

  boot_stream_loader dut_a (
    .clock(clock), .reset(reset), .dataOnPin(a_on), .dataPin(a_dat),
    .ready(a_ready), .out(a_out), .addr(a_addr),
    .busy(a_busy), .done(a_done), .error(a_error)
  );

  boot_stream_loader #(.LSB_FIRST(1)) dut_b (
    .clock(clock), .reset(reset), .dataOnPin(b_on), .dataPin(b_dat),
    .ready(b_ready), .out(b_out), .addr(b_addr),
    .busy(b_busy), .done(b_done), .error(b_error)
  );

  boot_stream_loader #(.ADDR_WIDTH(2)) dut_c (
    .clock(clock), .reset(reset), .dataOnPin(c_on), .dataPin(c_dat),
    .ready(c_ready), .out(c_out), .addr(c_addr),
    .busy(c_busy), .done(c_done), .error(c_error)
  );

  // Monitor: log every ready pulse and flag any pulse wider than one cycle.
  always @(negedge clock) begin
    if (a_ready) begin
      if (a_cnt < 64) begin a_addr_log[a_cnt] = a_addr; a_out_log[a_cnt] = a_out; end
      a_cnt++;
    end
    if (b_ready) begin
      if (b_cnt < 64) begin b_addr_log[b_cnt] = b_addr; b_out_log[b_cnt] = b_out; end
      b_cnt++;
    end
    if (c_ready) begin
      if (c_cnt < 64) begin c_addr_log[c_cnt] = {10'd0, c_addr}; c_out_log[c_cnt] = c_out; end
      c_cnt++;
    end
    if (a_ready && a_ready_q) a_double++;
    if (b_ready && b_ready_q) b_double++;
    if (c_ready && c_ready_q) c_double++;
    a_ready_q = a_ready;
    b_ready_q = b_ready;
    c_ready_q = c_ready;
    if (a_busy) a_busy_cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pins(input int sel, input logic on, input logic d);
    case (sel)
      0: begin a_on = on; a_dat = d; end
      1: begin b_on = on; b_dat = d; end
      default: begin c_on = on; c_dat = d; end
    endcase
  endtask

  // Data set up 4 cycles before the strobe edge, held 4 cycles after it.
  task automatic send_bit(input int sel, input logic b);
    set_pins(sel, 1'b0, b);
    repeat (4) @(negedge clock);
    set_pins(sel, 1'b1, b);
    repeat (4) @(negedge clock);
    set_pins(sel, 1'b0, b);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input bit lsb);
    for (int i = 0; i < 32; i++) begin
      send_bit(sel, lsb ? w[i] : w[31-i]);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int base;
    int busy_base;

    // ---- Reset state
    do_reset();
    check("rst_ready", {63'd0, a_ready}, 64'd0);
    check("rst_out", {32'd0, a_out}, 64'd0);
    check("rst_addr", {52'd0, a_addr}, 64'd0);
    check("rst_busy", {63'd0, a_busy}, 64'd0);
    check("rst_done", {63'd0, a_done}, 64'd0);
    check("rst_error", {63'd0, a_error}, 64'd0);

    // ---- Good 3-word frame
    base = a_cnt;
    send_word(0, 32'd3, 1'b0);
    check("t1_busy_hdr", {63'd0, a_busy}, 64'd1);
    send_word(0, 32'h11111111, 1'b0);
    send_word(0, 32'h22222222, 1'b0);
    send_word(0, 32'h33333333, 1'b0);
    check("t1_busy_pre_sum", {63'd0, a_busy}, 64'd1);
    send_word(0, 32'h66666666, 1'b0);
    check("t1_pulses", 64'(a_cnt - base), 64'd3);
    check("t1_addr0", {52'd0, a_addr_log[base]}, 64'd0);
    check("t1_addr1", {52'd0, a_addr_log[base+1]}, 64'd1);
    check("t1_addr2", {52'd0, a_addr_log[base+2]}, 64'd2);
    check("t1_out0", {32'd0, a_out_log[base]}, 64'h11111111);
    check("t1_out1", {32'd0, a_out_log[base+1]}, 64'h22222222);
    check("t1_out2", {32'd0, a_out_log[base+2]}, 64'h33333333);
    check("t1_busy", {63'd0, a_busy}, 64'd0);
    check("t1_done", {63'd0, a_done}, 64'd1);
    check("t1_error", {63'd0, a_error}, 64'd0);

    // ---- Bad checksum, then ignored traffic
    do_reset();
    base = a_cnt;
    send_word(0, 32'd3, 1'b0);
    send_word(0, 32'h11111111, 1'b0);
    send_word(0, 32'h22222222, 1'b0);
    send_word(0, 32'h33333333, 1'b0);
    send_word(0, 32'h66666667, 1'b0);
    check("t2_pulses", 64'(a_cnt - base), 64'd3);
    check("t2_error", {63'd0, a_error}, 64'd1);
    check("t2_done", {63'd0, a_done}, 64'd0);
    check("t2_busy", {63'd0, a_busy}, 64'd0);
    send_word(0, 32'h12345678, 1'b0);
    send_word(0, 32'h00000001, 1'b0);
    check("t2_after_pulses", 64'(a_cnt - base), 64'd3);
    check("t2_after_error", {63'd0, a_error}, 64'd1);
    check("t2_after_done", {63'd0, a_done}, 64'd0);
    check("t2_after_out", {32'd0, a_out}, 64'h33333333);
    check("t2_after_addr", {52'd0, a_addr}, 64'd2);

    // ---- Empty frame
    do_reset();
    base = a_cnt;
    send_word(0, 32'd0, 1'b0);
    check("t3_busy_empty", {63'd0, a_busy}, 64'd1);
    send_word(0, 32'd0, 1'b0);
    check("t3_pulses", 64'(a_cnt - base), 64'd0);
    check("t3_done", {63'd0, a_done}, 64'd1);
    check("t3_error", {63'd0, a_error}, 64'd0);

    // ---- Oversize header 4097
    do_reset();
    busy_base = a_busy_cyc;
    send_word(0, 32'd4097, 1'b0);
    check("t3_big_error", {63'd0, a_error}, 64'd1);
    check("t3_big_done", {63'd0, a_done}, 64'd0);
    check("t3_big_busy_seen", 64'(a_busy_cyc - busy_base), 64'd0);

    // ---- Timeout discards partial bits, both bit orders
    do_reset();
    base = a_cnt;
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1); send_bit(0, 1'b1); send_bit(0, 1'b0);
    send_bit(1, 1'b1); send_bit(1, 1'b0); send_bit(1, 1'b1); send_bit(1, 1'b1); send_bit(1, 1'b0);
    repeat (1024 + 5) @(negedge clock);
    send_word(0, 32'd1, 1'b0);
    send_word(0, 32'hA5A5A5A5, 1'b0);
    send_word(0, 32'hA5A5A5A5, 1'b0);
    check("t4_pulses", 64'(a_cnt - base), 64'd1);
    check("t4_addr", {52'd0, a_addr_log[base]}, 64'd0);
    check("t4_out", {32'd0, a_out_log[base]}, 64'hA5A5A5A5);
    check("t4_done", {63'd0, a_done}, 64'd1);
    check("t4_error", {63'd0, a_error}, 64'd0);
    base = b_cnt;
    send_word(1, 32'd1, 1'b1);
    send_word(1, 32'hA5A5A5A5, 1'b1);
    send_word(1, 32'hA5A5A5A5, 1'b1);
    check("t4l_pulses", 64'(b_cnt - base), 64'd1);
    check("t4l_addr", {52'd0, b_addr_log[base]}, 64'd0);
    check("t4l_out", {32'd0, b_out_log[base]}, 64'hA5A5A5A5);
    check("t4l_done", {63'd0, b_done}, 64'd1);
    check("t4l_error", {63'd0, b_error}, 64'd0);

    // ---- Reset in the middle of a load
    do_reset();
    base = a_cnt;
    send_word(0, 32'd5, 1'b0);
    send_word(0, 32'h0000AAAA, 1'b0);
    send_word(0, 32'h0000BBBB, 1'b0);
    check("t5_mid_pulses", 64'(a_cnt - base), 64'd2);
    check("t5_mid_busy", {63'd0, a_busy}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t5_rst_ready", {63'd0, a_ready}, 64'd0);
    check("t5_rst_out", {32'd0, a_out}, 64'd0);
    check("t5_rst_addr", {52'd0, a_addr}, 64'd0);
    check("t5_rst_busy", {63'd0, a_busy}, 64'd0);
    check("t5_rst_flags", {62'd0, a_done, a_error}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    base = a_cnt;
    send_word(0, 32'd1, 1'b0);
    send_word(0, 32'hDEADBEEF, 1'b0);
    send_word(0, 32'hDEADBEEF, 1'b0);
    check("t5_pulses", 64'(a_cnt - base), 64'd1);
    check("t5_addr", {52'd0, a_addr_log[base]}, 64'd0);
    check("t5_out", {32'd0, a_out_log[base]}, 64'hDEADBEEF);
    check("t5_done", {63'd0, a_done}, 64'd1);

    // ---- ADDR_WIDTH=2, full-depth frame
    do_reset();
    base = c_cnt;
    send_word(2, 32'd4, 1'b0);
    send_word(2, 32'd1, 1'b0);
    send_word(2, 32'd2, 1'b0);
    send_word(2, 32'd3, 1'b0);
    send_word(2, 32'd4, 1'b0);
    send_word(2, 32'd10, 1'b0);
    check("t6_pulses", 64'(c_cnt - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check("t6_addr", {52'd0, c_addr_log[base+k]}, 64'(k));
      check("t6_out", {32'd0, c_out_log[base+k]}, 64'(k + 1));
    end
    check("t6_done", {63'd0, c_done}, 64'd1);
    check("t6_error", {63'd0, c_error}, 64'd0);

    // ---- Ready never wider than one cycle on any instance
    check("ready_width_a", 64'(a_double), 64'd0);
    check("ready_width_b", 64'(b_double), 64'd0);
    check("ready_width_c", 64'(c_double), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
